// File: rtl/memory_bus_router.sv
// CPU memory bus router: decodes the CPU address into one of NUM_REGIONS slave
// regions, stalls the CPU until the selected slave is ready, and aborts hung accesses.
module memory_bus_router #(
    parameter int                    ADDR_WIDTH       = 24,
    parameter int                    DATA_WIDTH       = 8,
    parameter int                    NUM_REGIONS      = 4,
    parameter int                    REGION_LSB       = 14,
    parameter int                    HIGH_PAGE_REGION = 3,
    parameter int                    TIMEOUT_CYCLES   = 255,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA        = '1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic [DATA_WIDTH-1:0]             data_out,
    input  logic                              bus_enable,
    input  logic                              write_enable,
    output logic                              bus_halt,
    output logic                              bus_error,
    output logic [ADDR_WIDTH-1:0]             slave_address,
    output logic [DATA_WIDTH-1:0]             slave_data_out,
    output logic [NUM_REGIONS-1:0]            slave_enable,
    output logic [NUM_REGIONS-1:0]            slave_write_enable,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] slave_data_in,
    input  logic [NUM_REGIONS-1:0]            slave_ready,
    output logic [1:0]                        state_dbg
);

    localparam int RW = $clog2(NUM_REGIONS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         region_q, region_dec;
    logic                  write_q;
    logic                  err_q;
    logic [CW-1:0]         count_q;
    logic                  start, finish, timed_out;
    logic                  ready_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;

    assign state_dbg = state_q;
    assign ready_sel = slave_ready[region_q];
    assign rdata_sel = slave_data_in[int'(region_q)*DATA_WIDTH +: DATA_WIDTH];

    // Any address above the low 64 KiB page is routed to the high-page region.
    always_comb begin
        region_dec = address[REGION_LSB +: RW];
        if (address[ADDR_WIDTH-1:16] != '0)
            region_dec = RW'(HIGH_PAGE_REGION);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        bus_halt  = 1'b0;
        bus_error = 1'b0;
        case (state_q)
            IDLE: begin
                bus_halt = bus_enable;
                if (bus_enable) begin
                    start   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                bus_halt = 1'b1;
                // A ready arriving on the final allowed cycle beats the timeout.
                if (ready_sel) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                bus_error = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out           <= '0;
            slave_address      <= '0;
            slave_data_out     <= '0;
            slave_enable       <= '0;
            slave_write_enable <= '0;
            region_q           <= '0;
            write_q            <= 1'b0;
            err_q              <= 1'b0;
            count_q            <= '0;
        end else begin
            if (start) begin
                slave_address      <= address;
                slave_data_out     <= data_in;
                write_q            <= write_enable;
                region_q           <= region_dec;
                count_q            <= '0;
                err_q              <= 1'b0;
                slave_enable       <= NUM_REGIONS'(1) << region_dec;
                slave_write_enable <= write_enable ? (NUM_REGIONS'(1) << region_dec) : '0;
            end else if (state_q == ACCESS) begin
                count_q <= count_q + 1'b1;
                if (finish) begin
                    slave_enable       <= '0;
                    slave_write_enable <= '0;
                    err_q              <= timed_out;
                    // Timed-out writes are simply dropped; reads return filler.
                    if (!write_q)
                        data_out <= timed_out ? FILL_DATA : rdata_sel;
                end
            end else if (state_q == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/memory_bus_router.md
Name: memory_bus_router

Overview:
- Parametrised successor to the fixed four-bank CPU memory bus.
- Decodes the CPU address into one of NUM_REGIONS slave regions and latches each request.
- Holds the CPU (bus_halt) until the selected slave returns ready, so every region may have variable latency: block RAM, SPI flash, or peripherals.
- A per-access timeout guarantees forward progress: a hung slave is reported on bus_error and returns filler data.

Parameters:
- ADDR_WIDTH, 24, CPU address width.
- DATA_WIDTH, 8, data width.
- NUM_REGIONS, 4, slave count; power of two, 2..8.
- REGION_LSB, 14, lowest address bit of the region field; the field is log2(NUM_REGIONS) bits wide.
- HIGH_PAGE_REGION, 3, region selected whenever address[ADDR_WIDTH-1:16] != 0.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; >= 1.
- FILL_DATA, all-ones, read data returned on timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH  CPU address.
- data_in  input  DATA_WIDTH  CPU write data.
- data_out  output  DATA_WIDTH  registered read data to CPU.
- bus_enable  input  1  CPU access request.
- write_enable  input  1  1 = write, 0 = read; sampled with bus_enable.
- bus_halt  output  1  CPU must stall while high.
- bus_error  output  1  one-cycle pulse: the access just completed timed out.
- slave_address  output  ADDR_WIDTH  latched address, shared by all slaves.
- slave_data_out  output  DATA_WIDTH  latched write data, shared.
- slave_enable  output  NUM_REGIONS  one-hot select, registered.
- slave_write_enable  output  NUM_REGIONS  one-hot write strobe, registered.
- slave_data_in  input  NUM_REGIONS*DATA_WIDTH  read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- slave_ready  input  NUM_REGIONS  slave k completed the access.

Behaviour:
- Reset (reset=0, asynchronous):
  - State machine goes to IDLE; timeout counter clears.
  - data_out, slave_address, slave_data_out, slave_enable, slave_write_enable and bus_error all go to 0.
  - Any in-flight access is abandoned; the slave sees enable drop immediately.
- Region decode:
  - If the upper page address[ADDR_WIDTH-1:16] is nonzero, the region is HIGH_PAGE_REGION.
  - Otherwise the region is address[REGION_LSB +: log2(NUM_REGIONS)].
  - Decode happens only at request latch; address changes after latch are ignored.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - bus_halt = bus_enable (combinational), so the CPU stalls in the same cycle it requests.
  - On bus_enable=1: latch address, data_in, write_enable and the decoded region.
  - Set slave_enable[region]=1, plus slave_write_enable[region] if writing; clear the counter; go to ACCESS.
- ACCESS:
  - bus_halt=1; enables stay asserted and the counter increments each cycle.
  - If slave_ready[region]=1:
    - Read: data_out <= slave_data_in slice for that region.
    - Drop the enables and go to DONE.
  - Else, if counter == TIMEOUT_CYCLES-1:
    - Read: data_out <= FILL_DATA. Write: the write is discarded.
    - Set the error flag, drop the enables and go to DONE.
  - If ready and timeout coincide, ready wins and there is no error.
  - slave_ready of non-selected regions is ignored.
- DONE:
  - bus_halt=0; bus_error equals the error flag; go to IDLE and clear the error flag.
  - The CPU consumes data_out in this cycle.
- Latency:
  - Minimum 3 cycles per access: request, then ACCESS with ready=1, then DONE.
  - Each slave wait cycle adds 1.
  - Timeout costs TIMEOUT_CYCLES+2 cycles.
- Back-to-back: if bus_enable stays high through DONE, the next IDLE cycle latches a new request. There is no idle gap beyond IDLE itself.
- data_out holds its value until the next read completes; writes leave it unchanged.
- slave_address and slave_data_out hold their latched values until the next request.

Test Plan:
- Read region 0: address=0x000123, slave_ready[0] high immediately, slave_data_in[0]=0x5A.
  - slave_enable=0001 for exactly 1 cycle; bus_halt high 2 cycles; data_out=0x5A in DONE; bus_error=0.
- Write with waits: address=0x008004, data_in=0x3C, write_enable=1, slave_ready[2] asserted after 5 wait cycles.
  - slave_enable and slave_write_enable = 0100 for 6 cycles; slave_data_out=0x3C; bus_halt drops on cycle 8; data_out unchanged.
- High page: address=0x010000, reading.
  - Region 3 selected despite address[15:14]=00; slave_address=0x010000.
- Timeout: TIMEOUT_CYCLES=8, region 1 never ready.
  - ACCESS lasts 8 cycles; data_out=0xFF; bus_error high exactly in DONE.
  - Ready arriving on the 8th cycle instead returns real data with no error.
- Mid-access changes: change address mid-access; assert slave_ready on a non-selected region.
  - No effect; the access completes on the latched region only.
- Reset mid-operation: pull reset low during ACCESS.
  - All outputs go to 0 asynchronously, before the next clk edge.
  - After release, a new read completes normally in 3 cycles.
